// File: rtl/sel_pkg.sv
// Shared definitions for the rotating/fixed channel selector.
//   clog2      : constant function giving the channel-index width (never below 1).
//   MODE_FIXED : MODE value for external-select operation.
//   MODE_RR    : MODE value for round-robin operation.
package sel_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2 with a floor of 1 so a 2-channel build still gets a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sel_rr_arb.sv
// Combinational round-robin arbiter.
//   valid        : per-channel request vector.
//   ptr          : highest-priority channel for this cycle.
//   grant        : first requesting channel found scanning ptr, ptr+1, ... wrapping.
//   grant_exists : high when any channel requests.
module sel_rr_arb
  import sel_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [CW-1:0] ptr,
  output logic [CW-1:0] grant,
  output logic          grant_exists
);

  logic [CW:0]   sum;
  logic [CW-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant        = '0;
    grant_exists = 1'b0;
    sum          = '0;
    idx          = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (CW + 1)'(i);
      if (sum >= (CW + 1)'(N)) sum = sum - (CW + 1)'(N);
      idx = sum[CW-1:0];
      if (valid[idx]) begin
        grant        = idx;
        grant_exists = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sel_rr_mux.sv
// N-channel selector with valid/ready handshakes and a one-entry output register.
//   CLK, RST   : clock, asynchronous active-high reset.
//   MODE       : 0 = fixed (SEL picks the channel), 1 = round-robin.
//   SEL        : channel index used in fixed mode.
//   IN_DATA    : packed channel data, channel k at [k*W +: W].
//   IN_VALID   : per-channel valid.
//   IN_READY   : per-channel ready, combinational, at most one bit set.
//   OUT_DATA   : registered selected word.
//   OUT_CH     : registered index of the channel that supplied OUT_DATA.
//   OUT_VALID  : registered output valid.
//   OUT_READY  : downstream ready.
module sel_rr_mux
  import sel_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int CW = clog2(N)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          MODE,
  input  logic [CW-1:0] SEL,
  input  logic [N*W-1:0] IN_DATA,
  input  logic [N-1:0]  IN_VALID,
  output logic [N-1:0]  IN_READY,
  output logic [W-1:0]  OUT_DATA,
  output logic [CW-1:0] OUT_CH,
  output logic          OUT_VALID,
  input  logic          OUT_READY
);

  logic [CW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [CW-1:0] out_ch_q, out_ch_d;
  logic          out_valid_q, out_valid_d;

  logic [CW-1:0] rr_grant, grant;
  logic          rr_exists, grant_exists;
  logic          load, xfer;
  logic [W-1:0]  ch_data [N];
  logic [W-1:0]  grant_data;

  sel_rr_arb #(.N(N)) u_arb (
    .valid        (IN_VALID),
    .ptr          (ptr_q),
    .grant        (rr_grant),
    .grant_exists (rr_exists)
  );

  // Register can accept a new word when empty or being popped this cycle.
  assign load = ~out_valid_q | OUT_READY;

  // Fixed mode grants SEL regardless of its valid; out-of-range SEL grants nothing.
  always_comb begin
    if (MODE == MODE_RR) begin
      grant        = rr_grant;
      grant_exists = rr_exists;
    end else begin
      grant        = SEL;
      grant_exists = ({1'b0, SEL} < (CW + 1)'(N));
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    assign ch_data[gi]  = IN_DATA[gi*W +: W];
    // RST gate keeps producers from seeing a handshake while the register is held in reset.
    assign IN_READY[gi] = load & grant_exists & ~RST & (grant == CW'(gi));
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant == CW'(k)) grant_data = ch_data[k];
    end
  end

  assign xfer = |(IN_VALID & IN_READY);

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_ch_d    = grant;
      out_valid_d = 1'b1;
      if (MODE == MODE_RR) begin
        ptr_d = (grant == CW'(N - 1)) ? '0 : grant + CW'(1);
      end
    end else if (load) begin
      // Popped (or empty) with nothing new: invalidate but keep the last word visible.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_CH    = out_ch_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_sel_rr_mux.sv
module tb_sel_rr_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic         CLK;
  logic         RST;
  logic         MODE;
  logic [1:0]   SEL;
  logic [N*W-1:0] IN_DATA;
  logic [N-1:0] IN_VALID;
  logic [N-1:0] IN_READY;
  logic [W-1:0] OUT_DATA;
  logic [1:0]   OUT_CH;
  logic         OUT_VALID;
  logic         OUT_READY;

  int n_vec;
  int n_err;

  // Reference state: what the output register and rotation pointer should hold.
  int       m_ptr;
  bit       m_valid;
  int       m_data;
  int       m_ch;

  sel_rr_mux #(.N(N), .W(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .MODE      (MODE),
    .SEL       (SEL),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_CH    (OUT_CH),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant rule: fixed picks SEL; round-robin picks first valid from the pointer, wrapping.
  function automatic void model_grant(output bit ok, output int g);
    ok = 1'b0;
    g  = 0;
    if (MODE == 1'b0) begin
      g  = int'(SEL);
      ok = (g < N);
    end else begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (!ok && IN_VALID[k]) begin
          ok = 1'b1;
          g  = k;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = 0;
    m_ch    = 0;
  endfunction

  function automatic void set_data(input int d0, input int d1, input int d2, input int d3);
    IN_DATA = {d3[7:0], d2[7:0], d1[7:0], d0[7:0]};
  endfunction

  // One clock cycle: inputs already driven after a negedge.
  task automatic step(input string tag);
    bit         ok;
    int         g;
    bit         load;
    bit         xfer;
    logic [3:0] exp_rdy;
    #1;
    model_grant(ok, g);
    load    = !m_valid || OUT_READY;
    exp_rdy = (load && ok) ? 4'(1 << g) : 4'b0000;
    chk({tag, ".in_ready"}, 32'(IN_READY), 32'(exp_rdy));
    xfer = load && ok && IN_VALID[g];
    @(posedge CLK);
    #1;
    if (xfer) begin
      m_data  = int'(IN_DATA[g*W +: W]);
      m_ch    = g;
      m_valid = 1'b1;
      if (MODE) m_ptr = (g + 1) % N;
    end else if (load) begin
      m_valid = 1'b0;
    end
    chk({tag, ".out_valid"}, 32'(OUT_VALID), 32'(m_valid));
    chk({tag, ".out_data"},  32'(OUT_DATA),  32'(m_data));
    chk({tag, ".out_ch"},    32'(OUT_CH),    32'(m_ch));
    @(negedge CLK);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(OUT_VALID), 32'd0);
    chk({tag, ".out_data"},  32'(OUT_DATA),  32'd0);
    chk({tag, ".out_ch"},    32'(OUT_CH),    32'd0);
    chk({tag, ".in_ready"},  32'(IN_READY),  32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    RST       = 1'b1;
    MODE      = 1'b0;
    SEL       = 2'd0;
    IN_DATA   = '0;
    IN_VALID  = 4'b1111;
    OUT_READY = 1'b1;

    // Power-on reset.
    @(negedge CLK);
    @(negedge CLK);
    chk_reset_outputs("por");
    RST = 1'b0;

    // Fixed select of channel 2.
    MODE = 1'b0; SEL = 2'd2; IN_VALID = 4'b1111; OUT_READY = 1'b1;
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    #1 chk("fixed.ready_0100", 32'(IN_READY), 32'b0100);
    step("fixed");
    chk("fixed.data_33", 32'(OUT_DATA), 32'h33);

    // Round-robin rotation with every channel valid: pointer still 0 after fixed mode.
    MODE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("rr_rot");
      chk("rr_rot.seq", 32'(OUT_CH), 32'(i % N));
    end

    // Sparse round-robin: move pointer to 2, then only ch0/ch1 valid.
    IN_VALID = 4'b0010;
    step("rr_ptr2");
    IN_VALID = 4'b0011;
    step("rr_sparse0");
    chk("rr_sparse.first", 32'(OUT_CH), 32'd0);
    step("rr_sparse1");
    chk("rr_sparse.second", 32'(OUT_CH), 32'd1);

    // Backpressure: load AA, hold for 3 cycles, then release with ch3 offering 55.
    MODE = 1'b0; SEL = 2'd1; IN_VALID = 4'b0010;
    set_data(8'h00, 8'hAA, 8'h00, 8'h55);
    step("bp_load");
    OUT_READY = 1'b0; IN_VALID = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      chk("bp_hold.data_aa", 32'(OUT_DATA), 32'hAA);
    end
    OUT_READY = 1'b1; MODE = 1'b1; IN_VALID = 4'b1000;
    step("bp_release");
    chk("bp_release.data_55", 32'(OUT_DATA), 32'h55);
    chk("bp_release.ch3", 32'(OUT_CH), 32'd3);

    // Drain: valid drops one cycle after the last transfer, data retained.
    IN_VALID = 4'b0000;
    step("drain1");
    chk("drain.valid0", 32'(OUT_VALID), 32'd0);
    step("drain2");
    chk("drain.keep55", 32'(OUT_DATA), 32'h55);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      MODE      = 1'($urandom_range(0, 1));
      SEL       = 2'($urandom_range(0, 3));
      IN_VALID  = 4'($urandom);
      OUT_READY = ($urandom_range(0, 3) != 0);
      IN_DATA   = 32'($urandom);
      step("rand");
    end

    // Reset mid-cycle while holding a valid word.
    MODE = 1'b0; SEL = 2'd3; IN_VALID = 4'b1000; OUT_READY = 1'b1;
    set_data(8'h01, 8'h02, 8'h03, 8'h9C);
    step("pre_rst");
    chk("pre_rst.valid1", 32'(OUT_VALID), 32'd1);
    OUT_READY = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 chk_reset_outputs("mid_rst");
    @(negedge CLK);
    RST = 1'b0;
    model_reset();

    // Pointer back at 0 after reset.
    MODE = 1'b1; IN_VALID = 4'b1111; OUT_READY = 1'b1;
    step("post_rst");
    chk("post_rst.ch0", 32'(OUT_CH), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sel_rr_mux.md
Name: sel_rr_mux

Overview:
- Parametrised successor to the 4-1 selector: N channels of W-bit data, selected onto one registered output.
- Per-channel valid/ready handshakes on the inputs and one valid/ready handshake on the output.
- Two selection modes, chosen at run time: fixed (external SEL picks the channel) and round-robin (fair rotating grant among valid channels).
- Sits between several producers and a single downstream consumer. It replaces the combinational SEL modules wherever backpressure or fairness is required.

Parameters:
- N, 4, number of input channels; N >= 2.
- W, 8, data width per channel; W >= 1.
- CW, clog2(N), width of channel index; derived, not overridden.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- MODE  input  1  0 = fixed select, 1 = round-robin.
- SEL  input  CW  channel index used when MODE=0.
- IN_DATA  input  N*W  channel k occupies bits [k*W+W-1 : k*W].
- IN_VALID  input  N  per-channel valid.
- IN_READY  output  N  per-channel ready; combinational; at most one bit high.
- OUT_DATA  output  W  registered selected data.
- OUT_CH  output  CW  registered index of the channel that supplied OUT_DATA.
- OUT_VALID  output  1  registered output valid.
- OUT_READY  input  1  downstream ready.

Behaviour:
- Reset (RST=1, asynchronous): OUT_VALID=0, OUT_DATA=0, OUT_CH=0, round-robin pointer PTR=0. IN_READY=0 while RST=1.
- Output register: one entry. LOAD = ~OUT_VALID | OUT_READY.
- While OUT_VALID=1 and OUT_READY=0:
  - OUT_DATA, OUT_CH and OUT_VALID hold.
  - All IN_READY=0.
- Grant g, computed combinationally each cycle:
  - MODE=0: g = SEL. No grant if SEL >= N (only possible when N is not a power of 2).
  - MODE=1: first k in the order PTR, PTR+1, ..., N-1, 0, ..., PTR-1 with IN_VALID[k]=1. No grant if IN_VALID is all zero.
- IN_READY[g] = LOAD & grant_exists. All other IN_READY bits are 0.
- In MODE=0, IN_READY[SEL] depends only on LOAD, not on IN_VALID[SEL].
- Transfer on channel g when IN_VALID[g] & IN_READY[g]. On the next edge:
  - OUT_DATA <= channel g data.
  - OUT_CH <= g.
  - OUT_VALID <= 1.
- LOAD=1 with no transfer: OUT_VALID <= 0; OUT_DATA and OUT_CH hold their last value.
- Latency: input transfer to OUT_VALID is exactly 1 cycle. Throughput is one word per cycle when OUT_READY is held at 1.
- Simultaneous output pop and input push in the same cycle: the register is replaced; no bubble.
- PTR update (MODE=1 only, on a transfer): PTR <= g+1, wrapping to 0 when g = N-1. PTR is unchanged in MODE=0 and on cycles without a transfer.
- MODE or SEL change mid-operation: takes effect on the grant in that same cycle. A word already held in the output register is unaffected. PTR keeps its value across mode switches.
- Reset asserted mid-operation: the held output word is discarded; outputs return to reset values immediately.
- Round-robin fairness: a continuously valid channel is granted within N transfers.

Decomposition:
- Package sel_pkg:
  - clog2 constant function (minimum result 1).
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
- Sub-module sel_rr_arb (combinational). Inputs: valid vector and PTR. Outputs: grant index and grant_exists. Instantiated once.
- The output register, LOAD logic, fixed-mode path and PTR register stay in sel_rr_mux.

Test Plan (all at N=4, W=8):
- Reset: assert RST mid-cycle with OUT_VALID=1 -> OUT_VALID, OUT_DATA and OUT_CH drop to 0 immediately; IN_READY=0000.
- Fixed mode: MODE=0, SEL=2, IN_VALID=1111, data ch0..3 = 11,22,33,44, OUT_READY=1 -> IN_READY=0100; next cycle OUT_DATA=33, OUT_CH=2, OUT_VALID=1; PTR stays 0.
- Round-robin rotation: MODE=1, IN_VALID=1111 held, OUT_READY=1 -> OUT_CH sequence 0,1,2,3,0 on consecutive cycles; PTR wraps 3 -> 0.
- Sparse round-robin: MODE=1, PTR=2, IN_VALID=0011 -> grant ch0, OUT_CH=0, PTR becomes 1; next grant ch1.
- Backpressure: OUT_VALID=1 with OUT_DATA=AA, OUT_READY=0 for 3 cycles -> OUT_DATA=AA and OUT_VALID=1 hold, IN_READY=0000. Then OUT_READY=1 with ch3 valid (data 55) -> the same edge loads 55, OUT_CH=3.
- Drain: IN_VALID=0000, OUT_READY=1 -> OUT_VALID goes 0 one cycle after the last transfer; OUT_DATA retains its last value.
